// File: rtl/acc_stage.sv
// acc_stage: sums CNT input beats per result through an external N-bit adder.
//
// The block owns the accumulator and the control FSM; the adder sits outside
// so it can be shared or retimed. add_a/add_b/add_cin are driven
// combinationally from acc and in_data. add_sum/add_cout come back in the
// same cycle and are registered on every accepted beat.
//
// Ports
//   clk, rst          : clock (rising edge) and async active-high reset
//   in_valid/in_ready : input beat handshake, in_data is the operand
//   add_a/add_b/add_cin, add_sum/add_cout : external adder interface
//   out_valid/out_ready : result handshake
//   out_data, out_ovf : result and "a carry-out occurred in this result"
//
// Build option
//   ACC_SATURATE_EN : when defined, the first carry-out in a result pins the
//                     accumulator to all ones for the rest of that result.
//                     When undefined, the accumulator wraps modulo 2^N.
//                     out_ovf is the same in both builds.

module acc_stage #(
  parameter int N   = 32,
  parameter int CNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ovf
);

  localparam int CW = $clog2(CNT + 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  acc, acc_nxt;
  logic [CW-1:0] count;
  logic          ovf_sticky, ovf_nxt;
  logic          accept, last_beat, take_out;

  // adder operands: acc is zero in IDLE, so the first beat simply loads in_data
  assign add_a   = acc;
  assign add_b   = in_data;
  assign add_cin = 1'b0;

  assign accept    = in_valid && in_ready;
  assign take_out  = out_valid && out_ready;
  // count only ever reaches CNT-1 before an accept, so this marks the final beat
  assign last_beat = (count == CW'(CNT - 1));

  always_comb begin
    ovf_nxt = ovf_sticky | add_cout;
`ifdef ACC_SATURATE_EN
    // once a carry has been seen, hold all ones regardless of later sums
    acc_nxt = (add_cout || ovf_sticky) ? {N{1'b1}} : add_sum;
`else
    acc_nxt = add_sum;
`endif
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_beat ? DONE : ACC;
      ACC:     if (accept && last_beat) state_nxt = DONE;
      DONE:    if (take_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: stall input while a result is pending
  always_comb begin
    in_ready = (state != DONE);
  end

  // datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      count      <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
    end else if (state == DONE) begin
      // out_data/out_ovf intentionally keep their last value after handoff
      if (take_out) begin
        acc        <= '0;
        count      <= '0;
        ovf_sticky <= 1'b0;
        out_valid  <= 1'b0;
      end
    end else if (accept) begin
      acc        <= acc_nxt;
      ovf_sticky <= ovf_nxt;
      count      <= count + CW'(1);
      if (last_beat) begin
        out_data  <= acc_nxt;
        out_ovf   <= ovf_nxt;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acc_stage.sv
module tb_acc_stage;

  typedef struct packed {
    logic [31:0] d;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // CNT=4 instance
  logic        in_valid, in_ready, add_cin, add_cout, out_valid, out_ready, out_ovf;
  logic [31:0] in_data, add_a, add_b, add_sum, out_data;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  acc_stage #(.N(32), .CNT(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  // CNT=1 instance
  logic        in_valid1, in_ready1, add_cin1, add_cout1, out_valid1, out_ready1, out_ovf1;
  logic [31:0] in_data1, add_a1, add_b1, add_sum1, out_data1;
  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {32'd0, add_cin1};

  acc_stage #(.N(32), .CNT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_ovf(out_ovf1)
  );

  exp_t q[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboards
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_result", 64'(out_data), 64'hdead);
      else begin
        e = q.pop_front();
        check("out_data", 64'(out_data), 64'(e.d));
        check("out_ovf", 64'(out_ovf), 64'(e.o));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) check("unexpected_result1", 64'(out_data1), 64'hdead);
      else begin
        e = q1.pop_front();
        check("out_data1", 64'(out_data1), 64'(e.d));
        check("out_ovf1", 64'(out_ovf1), 64'(e.o));
      end
    end
  end

  // drive one beat; returns #1 after the accepting edge
  task automatic send(input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n == 200) check("send_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send1(input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    in_valid1 = 1'b1;
    in_data1  = d;
    while (!in_ready1 && n < 200) begin @(negedge clk); n++; end
    if (n == 200) check("send1_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1 in_valid1 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q1.size() != 0) && n < 200) begin @(negedge clk); n++; end
    check("drain", 64'(q.size() + q1.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;

    // reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_acc", 64'(add_a), 64'd0);
    check("rst_add_cin", 64'(add_cin), 64'd0);
    @(negedge clk) rst = 1'b0;

    // back-to-back 1,2,3,4 -> 10
    q.push_back('{d: 32'd10, o: 1'b0});
    send(32'd1); send(32'd2); send(32'd3); send(32'd4);
    @(negedge clk);
    check("t1_latency", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("t1_idle_valid", 64'(out_valid), 64'd0);
    check("t1_idle_acc", 64'(add_a), 64'd0);
    check("t1_idle_ready", 64'(in_ready), 64'd1);
    check("t1_hold_data", 64'(out_data), 64'd10);

    // gapped beats 7,0,9,1 -> 17
    q.push_back('{d: 32'd17, o: 1'b0});
    send(32'd7); repeat (3) @(negedge clk);
    send(32'd0); repeat (3) @(negedge clk);
    send(32'd9); repeat (3) @(negedge clk);
    send(32'd1);
    drain();

    // backpressure: result held, input stalled
    @(posedge clk); #1 out_ready = 1'b0;
    q.push_back('{d: 32'd4, o: 1'b0});
    send(32'd1); send(32'd1); send(32'd1); send(32'd1);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'd99;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_data", 64'(out_data), 64'd4);
      @(negedge clk);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    q.push_back('{d: 32'd14, o: 1'b0});
    send(32'd2); send(32'd3); send(32'd4); send(32'd5);
    drain();

    // carry-out: wrap or saturate
`ifdef ACC_SATURATE_EN
    q.push_back('{d: 32'hFFFFFFFF, o: 1'b1});
`else
    q.push_back('{d: 32'd2, o: 1'b1});
`endif
    send(32'hFFFFFFFF); send(32'd1); send(32'd2); send(32'd0);
    drain();

    // reset mid-accumulation discards the partial sum
    send(32'd5); send(32'd5);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_acc", 64'(add_a), 64'd0);
    @(negedge clk) rst = 1'b0;
    q.push_back('{d: 32'd20, o: 1'b0});
    send(32'd5); send(32'd5); send(32'd5); send(32'd5);
    drain();

    // CNT=1: every beat is a result
    q1.push_back('{d: 32'd3, o: 1'b0});
    q1.push_back('{d: 32'd4, o: 1'b0});
    send1(32'd3);
    @(negedge clk);
    check("cnt1_latency_a", 64'(out_valid1), 64'd1);
    send1(32'd4);
    @(negedge clk);
    check("cnt1_latency_b", 64'(out_valid1), 64'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_stage.md
ACC_STAGE -- requirements
Module: acc_stage

Interface
REQ-001 The block SHALL expose parameter N, default 32: operand, sum and result width in bits.
REQ-002 The block SHALL expose parameter CNT, default 4: number of input beats summed per result (legal range CNT >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 The block SHALL have port in_data, input, N bits: operand to accumulate.
REQ-008 The block SHALL have port add_a, output, N bits: drives the external N-bit adder a input.
REQ-009 The block SHALL have port add_b, output, N bits: drives the adder b input.
REQ-010 The block SHALL have port add_cin, output, 1 bit: drives the adder c_in input.
REQ-011 The block SHALL have port add_sum, input, N bits: adder sum output.
REQ-012 The block SHALL have port add_cout, input, 1 bit: adder c_out output.
REQ-013 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-014 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-015 The block SHALL have port out_data, output, N bits: accumulated result.
REQ-016 The block SHALL have port out_ovf, output, 1 bit: at least one carry-out occurred during this result.

Function
REQ-017 The block SHALL drive add_a, add_b and add_cin combinationally: add_a = acc register, add_b = in_data, add_cin = 0.
REQ-018 The block SHALL implement FSM states IDLE, ACC and DONE; in_ready SHALL be 1 in IDLE and ACC and 0 in DONE.
REQ-019 An accept SHALL be defined as in_valid && in_ready at a rising clk edge; when in_valid = 0, in_data is don't-care.
REQ-020 On every accept the block SHALL update acc <= add_sum, ovf_sticky <= ovf_sticky | add_cout, and count <= count + 1.
REQ-021 On an accept in IDLE the FSM SHALL go to ACC (or directly to DONE when CNT = 1); acc is 0 on entry to IDLE, so the first beat loads in_data.
REQ-022 When the accept brings count to CNT, in the same edge the FSM SHALL go to DONE with out_data <= add_sum (post-config rule), out_ovf <= ovf_sticky | add_cout, and out_valid <= 1, giving one cycle of latency from the CNT-th accept to out_valid.
REQ-023 In DONE, out_valid, out_data and out_ovf SHALL stay stable until out_valid && out_ready; in_valid is ignored.
REQ-024 On out_valid && out_ready the FSM SHALL go to IDLE and clear out_valid, acc, count and ovf_sticky; out_data and out_ovf SHALL hold their last values.
REQ-025 Gaps in in_valid SHALL not alter state; back-to-back accepts SHALL be supported every cycle in IDLE and ACC.
REQ-026 The count register SHALL be $clog2(CNT+1) bits wide, and no beat beyond CNT SHALL be absorbed into a result.

Reset
REQ-027 Asserting rst SHALL immediately set state IDLE, acc = 0, count = 0, ovf_sticky = 0, out_valid = 0, out_data = 0, and out_ovf = 0, regardless of clk.
REQ-028 A reset in the middle of an accumulation SHALL discard the partial sum; the first accept after rst deasserts starts a new result.

Configuration
REQ-029 The feature SHALL be controlled by the macro ACC_SATURATE_EN.
REQ-030 With ACC_SATURATE_EN defined, any accept with add_cout = 1 SHALL set acc (and out_data if final) to all ones, and all ones SHALL be held for the remaining beats of that result.
REQ-031 Without ACC_SATURATE_EN, acc SHALL wrap modulo 2^N (acc <= add_sum).
REQ-032 out_ovf SHALL behave identically with and without ACC_SATURATE_EN.

Verification (N=32, CNT=4 unless stated)
REQ-033 The bench SHALL check: rst, then beats 1,2,3,4 back-to-back with out_ready=1 -> out_valid=1 one cycle after the 4th accept, out_data=10, out_ovf=0, then back to IDLE.
REQ-034 The bench SHALL check: beats 7,0,9,1 with 3 idle cycles between beats -> out_data=17, out_ovf=0.
REQ-035 The bench SHALL check: result pending with out_ready=0 for 5 cycles and in_valid=1 throughout -> in_ready=0, out_data stable, no beat absorbed; the 4 beats after out_ready sum independently.
REQ-036 The bench SHALL check: beats FFFFFFFF,1,2,0 -> out_data=2 without ACC_SATURATE_EN, out_data=FFFFFFFF with it, and out_ovf=1 in both builds.
REQ-037 The bench SHALL check: rst pulsed mid-cycle after 2 beats -> out_valid=0 at once; then beats 5,5,5,5 -> out_data=20.
REQ-038 The bench SHALL check: CNT=1, beats 3 then 4 -> two results, out_data=3 then 4, each one cycle after its accept.
